// File: rtl/cmp_pkg.sv
// Shared types and the final operator mapping for the pipelined comparator.
package cmp_pkg;

  localparam int CMP_OP_W = 3;

  typedef enum logic [CMP_OP_W-1:0] {
    CMP_LT = 3'd0,
    CMP_LE = 3'd1,
    CMP_GT = 3'd2,
    CMP_GE = 3'd3,
    CMP_EQ = 3'd4,
    CMP_NE = 3'd5
  } cmp_op_e;

  // Returns {result, err}; illegal opcodes force result low and flag err.
  function automatic logic [1:0] cmp_map(input logic [CMP_OP_W-1:0] op, input logic lt,
                                         input logic eq);
    logic [1:0] r;
    r = 2'b01;
    case (op)
      CMP_LT:  r = {lt, 1'b0};
      CMP_LE:  r = {lt | eq, 1'b0};
      CMP_GT:  r = {~(lt | eq), 1'b0};
      CMP_GE:  r = {~lt, 1'b0};
      CMP_EQ:  r = {eq, 1'b0};
      CMP_NE:  r = {~eq, 1'b0};
      default: r = 2'b01;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cmp_pipe_signed_nway_if.sv
// Input/output handshake bundle for the pipelined comparator.
interface cmp_pipe_signed_nway_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
);
  logic                          in_valid;
  logic                          in_ready;
  logic [WIDTH-1:0]              in_a;
  logic [WIDTH-1:0]              in_b;
  logic [cmp_pkg::CMP_OP_W-1:0]  in_op;
  logic                          in_signed;
  logic [TAG_W-1:0]              in_tag;
  logic                          out_valid;
  logic                          out_ready;
  logic                          out_result;
  logic                          out_err;
  logic [TAG_W-1:0]              out_tag;

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_signed, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_err, out_tag
  );

  modport master (
    output in_valid, in_a, in_b, in_op, in_signed, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_err, out_tag
  );
endinterface

// File: rtl/cmp_chunk_stage.sv
// One comparator pipeline stage: resolves the low CHUNK bits of the remaining operands
// and registers lt/eq, the still-unresolved upper bits and the sideband.
module cmp_chunk_stage
  import cmp_pkg::*;
#(
  parameter int unsigned CHUNK = 8,
  parameter int unsigned REM_W = 24,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned KeepW = (REM_W > 0) ? REM_W : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_adv,
  input  logic                 i_valid,
  input  logic [CHUNK+REM_W-1:0] i_a,
  input  logic [CHUNK+REM_W-1:0] i_b,
  input  logic                 i_lt,
  input  logic                 i_eq,
  input  logic [CMP_OP_W-1:0]  i_op,
  input  logic                 i_signed,
  input  logic [TAG_W-1:0]     i_tag,
  output logic                 o_valid,
  output logic                 o_lt,
  output logic                 o_eq,
  output logic [KeepW-1:0]     o_a_rem,
  output logic [KeepW-1:0]     o_b_rem,
  output logic [CMP_OP_W-1:0]  o_op,
  output logic                 o_signed,
  output logic [TAG_W-1:0]     o_tag
);

  logic [CHUNK-1:0] w_ca, w_cb;
  logic             w_clt, w_ceq;
  logic [KeepW-1:0] w_a_keep, w_b_keep;

  logic                r_valid, r_lt, r_eq, r_signed;
  logic [KeepW-1:0]    r_a_rem, r_b_rem;
  logic [CMP_OP_W-1:0] r_op;
  logic [TAG_W-1:0]    r_tag;

  assign w_ca  = i_a[CHUNK-1:0];
  assign w_cb  = i_b[CHUNK-1:0];
  assign w_clt = (w_ca < w_cb);
  assign w_ceq = (w_ca == w_cb);

  // The most significant stage has nothing left to carry.
  if (REM_W > 0) begin : g_rem
    assign w_a_keep = i_a[CHUNK +: KeepW];
    assign w_b_keep = i_b[CHUNK +: KeepW];
  end else begin : g_norem
    assign w_a_keep = '0;
    assign w_b_keep = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_lt     <= 1'b0;
      r_eq     <= 1'b0;
      r_a_rem  <= '0;
      r_b_rem  <= '0;
      r_op     <= '0;
      r_signed <= 1'b0;
      r_tag    <= '0;
    end else if (i_adv) begin
      r_valid  <= i_valid;
      r_lt     <= w_clt | (w_ceq & i_lt);
      r_eq     <= w_ceq & i_eq;
      r_a_rem  <= w_a_keep;
      r_b_rem  <= w_b_keep;
      r_op     <= i_op;
      r_signed <= i_signed;
      r_tag    <= i_tag;
    end
  end

  assign o_valid  = r_valid;
  assign o_lt     = r_lt;
  assign o_eq     = r_eq;
  assign o_a_rem  = r_a_rem;
  assign o_b_rem  = r_b_rem;
  assign o_op     = r_op;
  assign o_signed = r_signed;
  assign o_tag    = r_tag;

endmodule

// File: rtl/cmp_pipe_signed_nway.sv
// Pipelined signed/unsigned magnitude comparator, CHUNK bits per stage LSB first,
// with a single global advance shared by every stage.
module cmp_pipe_signed_nway
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8,
  parameter int unsigned TAG_W = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  cmp_pipe_signed_nway_if.slave bus
);

  localparam int unsigned NSTAGES = WIDTH / CHUNK;

  logic                               w_adv;
  logic [NSTAGES:0]                   w_valid, w_lt, w_eq, w_signed;
  logic [NSTAGES:0][CMP_OP_W-1:0]     w_op;
  logic [NSTAGES:0][TAG_W-1:0]        w_tag;
  logic [NSTAGES-1:0][WIDTH-1:0]      w_a, w_b;
  logic [1:0]                         w_map;

  assign w_adv        = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  // Flipping the MSB turns a two's-complement compare into an unsigned one.
  assign w_a[0] = bus.in_signed ? {~bus.in_a[WIDTH-1], bus.in_a[WIDTH-2:0]} : bus.in_a;
  assign w_b[0] = bus.in_signed ? {~bus.in_b[WIDTH-1], bus.in_b[WIDTH-2:0]} : bus.in_b;

  assign w_valid[0]  = bus.in_valid;
  assign w_lt[0]     = 1'b0;
  assign w_eq[0]     = 1'b1;
  assign w_op[0]     = bus.in_op;
  assign w_signed[0] = bus.in_signed;
  assign w_tag[0]    = bus.in_tag;

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    localparam int unsigned InW   = WIDTH - k * CHUNK;
    localparam int unsigned RemW  = InW - CHUNK;
    localparam int unsigned KeepW = (RemW > 0) ? RemW : 1;

    logic [KeepW-1:0] w_a_rem, w_b_rem;

    cmp_chunk_stage #(
      .CHUNK(CHUNK),
      .REM_W(RemW),
      .TAG_W(TAG_W)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_adv    (w_adv),
      .i_valid  (w_valid[k]),
      .i_a      (w_a[k][InW-1:0]),
      .i_b      (w_b[k][InW-1:0]),
      .i_lt     (w_lt[k]),
      .i_eq     (w_eq[k]),
      .i_op     (w_op[k]),
      .i_signed (w_signed[k]),
      .i_tag    (w_tag[k]),
      .o_valid  (w_valid[k+1]),
      .o_lt     (w_lt[k+1]),
      .o_eq     (w_eq[k+1]),
      .o_a_rem  (w_a_rem),
      .o_b_rem  (w_b_rem),
      .o_op     (w_op[k+1]),
      .o_signed (w_signed[k+1]),
      .o_tag    (w_tag[k+1])
    );

    if (k < NSTAGES - 1) begin : g_fwd
      assign w_a[k+1] = {{(WIDTH - RemW){1'b0}}, w_a_rem};
      assign w_b[k+1] = {{(WIDTH - RemW){1'b0}}, w_b_rem};
    end else begin : g_last
      logic unused_rem;
      assign unused_rem = ^{w_a_rem, w_b_rem};
    end

    if (k > 0) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^{w_a[k][WIDTH-1:InW], w_b[k][WIDTH-1:InW]};
    end
  end

  logic unused_signed;
  assign unused_signed = w_signed[NSTAGES];

  always_comb begin
    w_map          = cmp_map(w_op[NSTAGES], w_lt[NSTAGES], w_eq[NSTAGES]);
    bus.out_valid  = w_valid[NSTAGES];
    bus.out_result = w_map[1];
    bus.out_err    = w_map[0];
    bus.out_tag    = w_tag[NSTAGES];
  end

endmodule
